// File: rtl/dsp_nco_sweep_if.sv
// Sweep controller <-> host/NCO signal bundle for dsp_nco_sweep.
// master = requester driving sweep setup; slave = the sweep controller.
interface dsp_nco_sweep_if #(
  parameter int unsigned PHI_WIDTH   = 32,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start;
  logic                   abort;
  logic [PHI_WIDTH-1:0]   f_start;
  logic [PHI_WIDTH-1:0]   f_stop;
  logic [PHI_WIDTH-1:0]   f_step;
  logic [DWELL_WIDTH-1:0] dwell;
  logic                   en;
  logic [PHI_WIDTH-1:0]   phi_inc;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell,
    input  en, phi_inc, busy, done
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell,
    output en, phi_inc, busy, done
  );
endinterface

// File: rtl/dsp_nco_sweep.sv
// Linear frequency sweep controller feeding an NCO phase increment.
// Optional macro DSP_NCO_SWEEP_LOOP_EN: repeat the sweep continuously until abort/reset.
module dsp_nco_sweep #(
  parameter int unsigned PHI_WIDTH   = 32,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dsp_nco_sweep_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [PHI_WIDTH-1:0]   cur;
  logic [PHI_WIDTH-1:0]   f_stop_l;
  logic [PHI_WIDTH-1:0]   f_step_l;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [DWELL_WIDTH-1:0] dwell_l;
  logic                   last;

`ifdef DSP_NCO_SWEEP_LOOP_EN
  logic [PHI_WIDTH-1:0]   f_start_l;
  logic                   last_init;
`endif

  logic                   en_q;
  logic [PHI_WIDTH-1:0]   phi_q;
  logic                   busy_q;
  logic                   done_q;

  logic [PHI_WIDTH:0]     sum;
  logic                   clamp;
  logic                   start_last;

  // One extra bit keeps cur+f_step from wrapping past the top of the range.
  always_comb begin
    sum   = {1'b0, cur} + {1'b0, f_step_l};
    clamp = (sum >= {1'b0, f_stop_l});
  end

  assign start_last = (sw.f_start >= sw.f_stop) || (sw.f_step == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      cnt      <= '0;
      last     <= 1'b0;
      f_stop_l <= '0;
      f_step_l <= '0;
      dwell_l  <= '0;
`ifdef DSP_NCO_SWEEP_LOOP_EN
      f_start_l <= '0;
      last_init <= 1'b0;
`endif
      en_q     <= 1'b0;
      phi_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (sw.abort) begin
      state  <= IDLE;
      en_q   <= 1'b0;
      phi_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (sw.start) begin
            f_stop_l <= sw.f_stop;
            f_step_l <= sw.f_step;
            dwell_l  <= sw.dwell;
`ifdef DSP_NCO_SWEEP_LOOP_EN
            f_start_l <= sw.f_start;
            last_init <= start_last;
`endif
            cur      <= sw.f_start;
            cnt      <= sw.dwell;
            last     <= start_last;
            state    <= RUN;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            phi_q    <= sw.f_start;
          end
        end

        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_WIDTH'(1);
          end else if (!last) begin
            cnt <= dwell_l;
            if (clamp) begin
              cur   <= f_stop_l;
              phi_q <= f_stop_l;
              last  <= 1'b1;
            end else begin
              cur   <= sum[PHI_WIDTH-1:0];
              phi_q <= sum[PHI_WIDTH-1:0];
            end
          end else begin
`ifdef DSP_NCO_SWEEP_LOOP_EN
            // Wrap straight back to the first frequency; en stays high.
            cur   <= f_start_l;
            phi_q <= f_start_l;
            cnt   <= dwell_l;
            last  <= last_init;
`else
            state  <= DONE;
            en_q   <= 1'b0;
            phi_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          en_q   <= 1'b0;
          phi_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw.en      = en_q;
  assign sw.phi_inc = phi_q;
  assign sw.busy    = busy_q;
  assign sw.done    = done_q;

endmodule

// File: tb/tb_dsp_nco_sweep.sv
// Self-checking bench for dsp_nco_sweep: directed cases plus randomized sweeps
// checked against a frequency-list model of the sweep.
module tb_dsp_nco_sweep;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_nco_sweep_if #(.PHI_WIDTH(PW), .DWELL_WIDTH(DW)) sw_if ();

  dsp_nco_sweep #(.PHI_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".en"},      64'(sw_if.en),      64'd0);
    check({tag, ".phi_inc"}, 64'(sw_if.phi_inc), 64'd0);
    check({tag, ".busy"},    64'(sw_if.busy),    64'd0);
    check({tag, ".done"},    64'(sw_if.done),    64'd0);
  endtask

  // Expected phase increment for every RUN cycle of one sweep.
  task automatic build_model(input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] fst, input logic [15:0] dw);
    longint unsigned f, s;
    bit last;
    exp_q.delete();
    f    = 64'(fs);
    last = (fs >= fe) || (fst == 32'd0);
    while (1) begin
      for (int k = 0; k <= int'(dw); k++) exp_q.push_back(f[31:0]);
      if (last) break;
      s = f + 64'(fst);
      if (s >= 64'(fe)) begin
        f    = 64'(fe);
        last = 1'b1;
      end else begin
        f = s;
      end
    end
  endtask

  task automatic apply(input logic [31:0] fs, input logic [31:0] fe,
                       input logic [31:0] fst, input logic [15:0] dw);
    sw_if.f_start = fs;
    sw_if.f_stop  = fe;
    sw_if.f_step  = fst;
    sw_if.dwell   = dw;
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] fs, input logic [31:0] fe,
                           input logic [31:0] fst, input logic [15:0] dw,
                           input bit scramble, input int restart_at);
    int reps;
    build_model(fs, fe, fst, dw);
    apply(fs, fe, fst, dw);
    sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
`ifdef DSP_NCO_SWEEP_LOOP_EN
    reps = 2;
`else
    reps = 1;
`endif
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check({tag, ".run_en"},   64'(sw_if.en),      64'd1);
        check({tag, ".run_busy"}, 64'(sw_if.busy),    64'd1);
        check({tag, ".run_done"}, 64'(sw_if.done),    64'd0);
        check({tag, ".run_phi"},  64'(sw_if.phi_inc), 64'(exp_q[i]));
        if (scramble) apply($urandom, $urandom, $urandom, 16'($urandom));
        sw_if.start = (i == restart_at) ? 1'b1 : 1'b0;
        tick();
      end
    end
    sw_if.start = 1'b0;
`ifdef DSP_NCO_SWEEP_LOOP_EN
    sw_if.abort = 1'b1;
    tick();
    sw_if.abort = 1'b0;
    check_idle({tag, ".after_abort"});
`else
    check({tag, ".end_en"},   64'(sw_if.en),      64'd0);
    check({tag, ".end_phi"},  64'(sw_if.phi_inc), 64'd0);
    check({tag, ".end_busy"}, 64'(sw_if.busy),    64'd0);
    check({tag, ".end_done"}, 64'(sw_if.done),    64'd1);
    tick();
    check_idle({tag, ".idle1"});
`endif
    tick();
    check_idle({tag, ".idle2"});
  endtask

  initial begin
    longint unsigned t;
    logic [31:0] fs, fe, fst;
    logic [15:0] dw;

    sw_if.start = 1'b0;
    sw_if.abort = 1'b0;
    apply(32'd0, 32'd0, 32'd0, 16'd0);

    #12;
    check_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    run_sweep("basic",  32'd100, 32'd130, 32'd10, 16'd2, 1'b0, -1);
    run_sweep("noWrap", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0, -1);
    run_sweep("step0",  32'd50, 32'd80, 32'd0, 16'd3, 1'b1, 1);
    run_sweep("startGeStop", 32'd500, 32'd400, 32'd7, 16'd1, 1'b0, 0);

    // Abort in the 5th RUN cycle: outputs drop on the next edge, no done.
    apply(32'd100, 32'd130, 32'd10, 16'd2);
    sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort.pre_phi", 64'(sw_if.phi_inc), (i < 3) ? 64'd100 : 64'd110);
      if (i < 4) tick();
    end
    sw_if.abort = 1'b1;
    tick();
    sw_if.abort = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_idle("abort.post");
      tick();
    end

    // Abort wins over a simultaneous start.
    sw_if.start = 1'b1;
    sw_if.abort = 1'b1;
    tick();
    sw_if.start = 1'b0;
    sw_if.abort = 1'b0;
    check_idle("abort_vs_start");

    // Asynchronous reset mid-sweep, then wait for a fresh start.
    sw_if.start = 1'b1;
    tick();
    sw_if.start = 1'b0;
    repeat (3) tick();
    check("rst.pre_en", 64'(sw_if.en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst.async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("rst.after");
    end
    run_sweep("after_rst", 32'd100, 32'd130, 32'd10, 16'd2, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      fs = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 + 32'($urandom_range(0, 255))) : $urandom;
      if ($urandom_range(0, 4) == 0) begin
        fe = fs - 32'($urandom_range(0, 50));
      end else begin
        t  = 64'(fs) + 64'($urandom_range(0, 200));
        fe = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
      end
      fst = 32'($urandom_range(0, 60));
      dw  = 16'($urandom_range(0, 3));
      run_sweep("rand", fs, fe, fst, dw, 1'b1, int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_nco_sweep.md
DSP_NCO_SWEEP -- requirements
Module: dsp_nco_sweep

Interface
REQ-001 Parameter: PHI_WIDTH, 32, width of the frequency control words.
REQ-002 Parameter: DWELL_WIDTH, 16, width of the dwell counter.
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  single-cycle sweep request.
REQ-006 Port: abort  in  1  stops the sweep immediately.
REQ-007 Port: f_start  in  PHI_WIDTH  first phase increment, unsigned.
REQ-008 Port: f_stop  in  PHI_WIDTH  final phase increment, unsigned.
REQ-009 Port: f_step  in  PHI_WIDTH  increment added per step, unsigned.
REQ-010 Port: dwell  in  DWELL_WIDTH  each frequency is held for dwell+1 cycles.
REQ-011 Port: en  out  1  NCO enable; drives the downstream NCO en input.
REQ-012 Port: phi_inc  out  PHI_WIDTH  frequency control word to the NCO.
REQ-013 Port: busy  out  1  high while in RUN.
REQ-014 Port: done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL do the following: latch f_start, f_stop, f_step and dwell; load cur=f_start and cnt=dwell; enter RUN.
REQ-017 In RUN: en=1, busy=1, phi_inc=cur. First RUN cycle is the cycle after the sampling edge of start.
REQ-018 In RUN with cnt!=0: cnt SHALL decrement by one.
REQ-019 In RUN with cnt==0 and the last flag clear: cnt SHALL reload with dwell; cur SHALL become min(cur+f_step, f_stop); the sum SHALL be computed at PHI_WIDTH+1 bits so that it never wraps.
REQ-020 When the clamp to f_stop takes effect (sum>=f_stop), the last flag SHALL set.
REQ-021 The last flag SHALL be set at start when f_start>=f_stop or f_step==0; the sweep is then a single dwell at f_start.
REQ-022 In RUN with cnt==0 and the last flag set: go to DONE; en=0; phi_inc=0; busy=0.
REQ-023 In DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-024 In IDLE: en=0, phi_inc=0, busy=0, done=0.
REQ-025 start while in RUN or DONE SHALL be ignored.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge with en=0 and phi_inc=0, with no done pulse; abort SHALL take priority over a simultaneous start.
REQ-027 Input changes during RUN SHALL have no effect; only the latched copies are used.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following: state=IDLE; en=0; phi_inc=0; busy=0; done=0; cur, cnt and the last flag cleared.
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep; after release, the block SHALL wait for a new start.

Configuration
REQ-030 Macro DSP_NCO_SWEEP_LOOP_EN defined: when the last dwell ends, the block SHALL reload cur=f_start, cnt=dwell and the last flag from the latched values and stay in RUN, with no done pulse and en continuously high, until abort or reset.
REQ-031 Macro DSP_NCO_SWEEP_LOOP_EN undefined: single sweep per start as in REQ-022..023; no loop logic present.

Verification
REQ-032 f_start=100, f_stop=130, f_step=10, dwell=2, one start pulse -> phi_inc 100,100,100,110,110,110,120,120,120,130,130,130 with en=1 (12 cycles); next cycle en=0, phi_inc=0, done=1 for one cycle.
REQ-033 f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20, dwell=0 -> phi_inc 0xFFFFFFF0 then 0xFFFFFFFF (clamped, no wrap to 0x10), then done.
REQ-034 f_step=0, f_start=50, f_stop=80, dwell=3 -> phi_inc=50 for 4 cycles, then done; start pulsed during RUN -> no restart or extension.
REQ-035 Abort asserted in the 5th RUN cycle of the REQ-032 setup -> en=0 and phi_inc=0 on the next edge, done never asserted; rst_n pulsed low mid-sweep -> outputs zero immediately.
REQ-036 With DSP_NCO_SWEEP_LOOP_EN and the REQ-032 setup -> the 12-cycle pattern repeats back-to-back with en held high and no done pulse, until abort.
